fifo_wr_arbiter: RTL and testbench

Write-side scheduler for the CDC FIFO: it shares the FIFO's single write port between two producer streams using round-robin with bounded bursts. It honours FIFO `full` backpressure and keeps per-requester beat counts for debug readout through the top-level I/O. It runs entirely in the FIFO write-clock domain and sits between the producers and the FIFO write port.

---
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Write-port scheduler for the CDC FIFO: two producers share one write port
// using round-robin arbitration with bounded bursts and FIFO-full backpressure.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    output logic              s1_ready,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              gnt,
    output logic [7:0]        cnt0,
    output logic [7:0]        cnt1
);

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t     state, state_nxt;
    logic       gnt_nxt;
    logic       last, last_nxt;
    logic [3:0] beats, beats_nxt;
    logic       gnt_valid, other_valid;
    logic       xfer, rel;

    assign gnt_valid   = gnt ? s1_valid : s0_valid;
    assign other_valid = gnt ? s0_valid : s1_valid;
    assign busy        = (state == BURST);
    assign xfer        = busy & gnt_valid & ~fifo_full;
    // Backpressure alone never ends a grant; only an exhausted burst or a
    // withdrawn valid does.
    assign rel         = (xfer & (beats == LAST_BEAT)) | ~gnt_valid;

    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = gnt ? s1_data : s0_data;
    assign s0_ready     = xfer & ~gnt;
    assign s1_ready     = xfer & gnt;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        beats_nxt = beats;
        case (state)
            IDLE: begin
                if (s0_valid & s1_valid) begin
                    gnt_nxt   = ~last;
                    beats_nxt = '0;
                    state_nxt = BURST;
                end else if (s0_valid | s1_valid) begin
                    gnt_nxt   = s1_valid;
                    beats_nxt = '0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (xfer) beats_nxt = beats + 4'd1;
                if (rel) begin
                    last_nxt = gnt;
                    if (other_valid) begin
                        gnt_nxt   = ~gnt;
                        beats_nxt = '0;
                    end else if (gnt_valid) begin
                        beats_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            beats <= '0;
            cnt0  <= '0;
            cnt1  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            beats <= beats_nxt;
            // Counters advance on the same edge the beat lands in the FIFO.
            if (s0_ready) cnt0 <= cnt0 + 8'd1;
            if (s1_ready) cnt1 <= cnt1 + 8'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter, checked cycle by cycle against a
// grant/burst reference model kept in plain integers.
module tb_fifo_wr_arbiter;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s0_valid = 1'b0, s1_valid = 1'b0;
    logic [DATA_W-1:0] s0_data = '0, s1_data = '0;
    logic              s0_ready, s1_ready;
    logic              fifo_full = 1'b0;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              busy, gnt;
    logic [7:0]        cnt0, cnt1;

    fifo_wr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .busy(busy), .gnt(gnt), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Producer state: a valid that has not been accepted is held with its data.
    bit                vld[2];
    bit                hold[2];
    logic [DATA_W-1:0] dat[2];
    int                pv[2];
    int                pf;

    // Reference model: who owns the port, how many beats they got this grant.
    bit act;
    int own, prev, n, tot1;
    int cnt[2];

    task automatic model_reset();
        act = 0; own = 0; prev = 1; n = 0;
        cnt[0] = 0; cnt[1] = 0;
        hold[0] = 0; hold[1] = 0;
    endtask

    task automatic model_edge();
        bit acc[2];
        bit gv, xf;
        acc[0] = 0; acc[1] = 0;
        if (!act) begin
            if (vld[0] && vld[1]) begin own = 1 - prev; act = 1; n = 0; end
            else if (vld[0] || vld[1]) begin own = vld[1] ? 1 : 0; act = 1; n = 0; end
        end else begin
            gv = vld[own];
            xf = gv && !fifo_full;
            acc[own] = xf;
            if (xf) begin
                n++;
                cnt[own] = (cnt[own] + 1) % 256;
                if (own == 1) tot1++;
            end
            if ((xf && n == MAX_BURST) || !gv) begin
                prev = own;
                if (vld[1-own]) begin own = 1 - own; n = 0; end
                else if (gv) n = 0;
                else act = 0;
            end
        end
        for (int i = 0; i < 2; i++) hold[i] = vld[i] && !acc[i];
    endtask

    // One cycle, entered just after a rising edge.
    task automatic step();
        bit xf;
        for (int i = 0; i < 2; i++) begin
            if (!hold[i]) begin
                vld[i] = ($urandom_range(99) < pv[i]);
                dat[i] = DATA_W'($urandom);
            end
        end
        s0_valid = vld[0]; s0_data = dat[0];
        s1_valid = vld[1]; s1_data = dat[1];
        fifo_full = ($urandom_range(99) < pf);
        #2;
        xf = act && vld[own] && !fifo_full;
        chk("busy", busy, act);
        chk("gnt", gnt, own[0]);
        chk("wr_en", fifo_wr_en, xf);
        chk("s0_ready", s0_ready, xf && own == 0);
        chk("s1_ready", s1_ready, xf && own == 1);
        chk("cnt0", cnt0, cnt[0]);
        chk("cnt1", cnt1, cnt[1]);
        if (xf) chk("wr_data", fifo_wr_data, dat[own]);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Asynchronous reset applied mid-cycle; effects must be immediate.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        vld[0] = 0; vld[1] = 0;
        s0_valid = 0; s1_valid = 0; fifo_full = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic phase(input int p0, input int p1, input int pfull, input int cycles);
        pv[0] = p0; pv[1] = p1; pf = pfull;
        for (int c = 0; c < cycles; c++) step();
    endtask

    initial begin
        tot1 = 0;
        model_reset();
        #3;
        do_reset();

        // Tie from reset: s0 first, then strict 4-beat alternation.
        phase(100, 100, 0, 13);
        chk("tie_cnt0", cnt0, 8);
        chk("tie_cnt1", cnt1, 4);
        phase(100, 100, 0, 20);

        // Mixed random traffic with backpressure and early releases.
        phase(60, 60, 30, 1500);
        phase(85, 30, 10, 800);
        phase(20, 90, 50, 800);

        // Reset in the middle of an s0 burst, then a tie goes to s0.
        do_reset();
        phase(100, 0, 0, 3);
        chk("mid_busy", busy, 1);
        do_reset();
        phase(100, 100, 0, 2);
        chk("post_rst_gnt", gnt, 0);
        phase(100, 100, 20, 30);

        // Counter wrap: 257 beats from s1 alone.
        do_reset();
        tot1 = 0;
        pv[0] = 0; pv[1] = 90; pf = 25;
        for (int c = 0; c < 3000 && tot1 < 257; c++) step();
        chk("wrap_done", tot1 >= 257, 1);
        pv[1] = 0;
        step();
        chk("wrap_cnt1", cnt1, 8'h01);
        chk("wrap_cnt0", cnt0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
